// File: rtl/dmem_if.sv
// Load/store request and response channels between the memory stage and the data RAM.
// The memory stage drives the master side; the responder takes the slave side.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM responder: one request at a time, fixed access latency, held response.
// state | meaning
// IDLE  | ready for a request; captures it and loads the latency counter
// BUSY  | counting down; access commits on the edge where count == 1
// RESP  | response held until resp_ready is sampled high
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit LAT0 = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic          write_q, write_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          err_q, err_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          resp_err_q, resp_err_d;

  logic          accept, req_err;
  logic          commit, commit_write, commit_err;
  logic [AW-1:0] commit_idx;
  logic [31:0]   commit_wdata, commit_rdata;
  logic [3:0]    commit_be;
  logic [31:0]   rd_arr [DEPTH];

  assign accept  = (state_q == IDLE) && req_ready_q && bus.req_valid;
  // Range check on the full word address so high address bits cannot alias into the array.
  assign req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:2] >= 30'(DEPTH));

  always_comb begin
    commit       = 1'b0;
    commit_write = write_q;
    commit_idx   = idx_q;
    commit_wdata = wdata_q;
    commit_be    = be_q;
    commit_err   = err_q;
    if (state_q == BUSY && count_q == 4'd1) commit = 1'b1;
    if (LAT0 && accept) begin
      commit       = 1'b1;
      commit_write = bus.req_write;
      commit_idx   = bus.req_addr[AW+1:2];
      commit_wdata = bus.req_wdata;
      commit_be    = bus.req_be;
      commit_err   = req_err;
    end
    commit = commit && rst;
    commit_rdata = (commit_write || commit_err) ? 32'h0 : rd_arr[commit_idx];
  end

  // Each word powers up holding its own index; reset leaves contents alone.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word_q = 32'(i);
    logic [31:0] word_d;
    always_comb begin
      word_d = word_q;
      if (commit && commit_write && !commit_err && commit_idx == AW'(i)) begin
        for (int b = 0; b < 4; b++)
          if (commit_be[b]) word_d[8*b +: 8] = commit_wdata[8*b +: 8];
      end
    end
    always_ff @(posedge clk) word_q <= word_d;
    assign rd_arr[i] = word_q;
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    write_d      = write_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    err_d        = err_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          write_d     = bus.req_write;
          idx_d       = bus.req_addr[AW+1:2];
          wdata_d     = bus.req_wdata;
          be_d        = bus.req_be;
          err_d       = req_err;
          count_d     = 4'(LATENCY);
          req_ready_d = 1'b0;
          state_d     = LAT0 ? RESP : BUSY;
        end
      end
      BUSY: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          rdata_d      = 32'h0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      resp_valid_d = 1'b1;
      rdata_d      = commit_rdata;
      resp_err_d   = commit_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= 4'd0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      write_q      <= write_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance driven from a vector table and corner
// sequences, plus a LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if b2();
  dmem_if b0();

  dmem_responder #(.DEPTH(128), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  dmem_responder #(.DEPTH(128), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wait_ready2(input string nm);
    int cyc = 0;
    while (!b2.req_ready && cyc < 20) begin step(); cyc++; end
    if (cyc >= 20) chk({nm, "_ready_timeout"}, 32'(cyc), 32'd0);
  endtask

  task automatic wait_resp2(input string nm, output int lat);
    lat = 0;
    while (!b2.resp_valid && lat < 20) begin
      chk({nm, "_busy_rdy"}, b2.req_ready, 1'b0);
      step();
      lat++;
    end
    if (lat >= 20) chk({nm, "_resp_timeout"}, 32'(lat), 32'd0);
  endtask

  task automatic pop_cmp(input string nm, input logic [31:0] rdata, input logic err);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({nm, "_rdata"}, rdata, e.rdata);
    chk({nm, "_err"}, err, e.err);
  endtask

  task automatic issue2(input vec_t v, input string nm);
    exp_t e;
    int   lat;
    wait_ready2(nm);
    b2.req_valid = 1'b1;
    b2.req_write = v.w;
    b2.req_addr  = v.addr;
    b2.req_wdata = v.wdata;
    b2.req_be    = v.be;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sbq.push_back(e);
    step();
    // Scramble the request fields after acceptance; the transaction must not see them.
    b2.req_valid = 1'b0;
    b2.req_write = ~v.w;
    b2.req_addr  = 32'h0000_001C;
    b2.req_wdata = 32'h5555_AAAA;
    b2.req_be    = 4'hF;
    wait_resp2(nm, lat);
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    pop_cmp(nm, b2.resp_rdata, b2.resp_err);
    step();
    chk({nm, "_valid_drop"}, b2.resp_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = 32'h0;
    b2.req_wdata = 32'h0; b2.req_be = 4'h0; b2.resp_ready = 1'b1;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = 32'h0;
    b0.req_wdata = 32'h0; b0.req_be = 4'h0; b0.resp_ready = 1'b1;

    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0000_0004, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h5, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h00AD_00EF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0200, 32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0015, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h0000_0005, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0000_0004, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0030, 32'h0,         4'h0, 32'h0000_000C, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_01FC, 32'hA5A5_A5A5, 4'h8, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_01FC, 32'h0,         4'h0, 32'hA500_007F, 1'b0});

    // Reset behaviour
    step(); step(); step();
    chk("rst_req_ready", b2.req_ready, 1'b0);
    chk("rst_resp_valid", b2.resp_valid, 1'b0);
    chk("rst_resp_rdata", b2.resp_rdata, 32'h0);
    chk("rst_resp_err", b2.resp_err, 1'b0);
    chk("rst_req_ready_l0", b0.req_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("post_rst_req_ready", b2.req_ready, 1'b1);

    foreach (vecs[i]) issue2(vecs[i], $sformatf("vec%0d", i));

    // Held response with a pending request that must wait for IDLE
    begin
      int lat;
      logic [31:0] held;
      wait_ready2("hold");
      b2.resp_ready = 1'b0;
      b2.req_valid = 1'b1; b2.req_write = 1'b0; b2.req_addr = 32'h0000_0010;
      sbq.push_back('{32'h0000_0004, 1'b0});
      step();
      b2.req_addr = 32'h0000_0014;
      wait_resp2("hold", lat);
      held = b2.resp_rdata;
      pop_cmp("hold", b2.resp_rdata, b2.resp_err);
      for (int i = 0; i < 5; i++) begin
        chk("hold_valid", b2.resp_valid, 1'b1);
        chk("hold_rdata", b2.resp_rdata, held);
        chk("hold_req_ready", b2.req_ready, 1'b0);
        step();
      end
      b2.resp_ready = 1'b1;
      sbq.push_back('{32'h0000_0005, 1'b0});
      step();
      chk("hs_valid_drop", b2.resp_valid, 1'b0);
      chk("hs_not_accepted", b2.req_ready, 1'b1);
      step();
      chk("next_accepted", b2.req_ready, 1'b0);
      b2.req_valid = 1'b0;
      wait_resp2("next", lat);
      chk("next_latency", 32'(lat), 32'd2);
      pop_cmp("next", b2.resp_rdata, b2.resp_err);
      step();
    end

    // Reset during BUSY drops an uncommitted store
    wait_ready2("rstmid");
    b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 32'h0000_0004;
    b2.req_wdata = 32'h1234_5678; b2.req_be = 4'hF;
    step();
    b2.req_valid = 1'b0;
    chk("rstmid_busy", b2.req_ready, 1'b0);
    rst = 1'b0;
    step();
    chk("rstmid_req_ready", b2.req_ready, 1'b0);
    chk("rstmid_resp_valid", b2.resp_valid, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstmid_no_resp", b2.resp_valid, 1'b0);
    end
    chk("rstmid_idle", b2.req_ready, 1'b1);
    issue2('{1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h0000_0001, 1'b0}, "rstmid_load4");
    issue2('{1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h00AD_00EF, 1'b0}, "rstmid_load20");

    // LATENCY=0: back-to-back loads of words 0, 1, 2
    begin
      int   n_acc = 0, n_resp = 0, cyc = 0, last_acc = -10;
      logic rdy;
      b0.resp_ready = 1'b1;
      b0.req_write = 1'b0;
      b0.req_addr = 32'h0;
      b0.req_valid = 1'b1;
      while (n_resp < 3 && cyc < 40) begin
        rdy = b0.req_ready;
        step();
        cyc++;
        if (rdy && b0.req_valid) begin
          if (n_acc > 0) chk("l0_spacing", 32'(cyc - last_acc), 32'd2);
          last_acc = cyc;
          sbq.push_back('{32'(n_acc), 1'b0});
          n_acc++;
          if (n_acc < 3) b0.req_addr = 32'(4 * n_acc);
          else b0.req_valid = 1'b0;
        end
        if (b0.resp_valid) begin
          chk("l0_latency", 32'(cyc - last_acc), 32'd0);
          pop_cmp($sformatf("l0_resp%0d", n_resp), b0.resp_rdata, b0.resp_err);
          n_resp++;
        end
      end
      chk("l0_resp_count", 32'(n_resp), 32'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS pipeline's load/store port: accepts one request at a time from the memory stage over a valid/ready handshake. It models a 128-word, 32-bit data RAM with a configurable access latency. It returns read data or a write acknowledgment over a separate valid/ready response channel. It sits where the memory stage's inline data array sits today and lets that stage be built and tested as a stalling initiator.

## Interface
- DEPTH, 128: number of 32-bit words; legal word index 0..DEPTH-1.
- LATENCY, 2: wait cycles between request acceptance and response; 0..15 legal.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[31:2].
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit k writes byte lane k (bits 8k+7:8k). Ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned (req_addr[1:0] != 0) or out of range (word index >= DEPTH).

## Operation
- Storage: DEPTH x 32 array. Each word i is initialised to i at simulation start. Reset does not clear the array.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture write, addr, wdata, be and err. Load count = LATENCY. Go to BUSY, or to RESP if LATENCY=0.
  - BUSY: count decrements each cycle. In the cycle count==1, the access commits at the clock edge and the FSM moves to RESP.
  - RESP: resp_valid=1. Outputs are held stable until resp_ready=1, then the FSM returns to IDLE.
- Commit rules:
  - A store with err=0 writes the enabled byte lanes only.
  - A load with err=0 registers the array word into resp_rdata.
  - If err=1, the array is unchanged, resp_rdata=0 and resp_err=1.
  - With LATENCY=0, the commit happens on the accept edge itself.
- req_ready=0 in BUSY and RESP. req_* inputs are ignored there.
- Request fields are captured only at acceptance. Later changes to req_* do not affect the transaction in flight.
- Read of a word written by the immediately preceding request returns the new data, because the store has fully committed before IDLE is re-entered.
- req_be=4'b0000 store: no array change, normal ack (err=0).
- Count register width is 4 bits; no wrap occurs because it is reloaded only in IDLE.

## Timing
- Reset values: req_ready=0 while rst=0, then 1 in the first cycle after reset deasserts (state IDLE). resp_valid=0, resp_rdata=0, resp_err=0, count=0.
- Latency: request accepted at edge T produces resp_valid=1 in the cycle after edge T+LATENCY.
  - LATENCY=2: accept at edge 0; BUSY during cycles 1–2; resp_valid high from cycle 3.
- Throughput: with resp_ready held high, one transaction completes every LATENCY+2 cycles (accept, LATENCY waits, response, IDLE).
- Response hold: resp_valid, resp_rdata and resp_err are stable from first assertion until the edge where resp_ready=1 is sampled. resp_valid falls in the next cycle.
- Simultaneous events: req_valid in RESP is not accepted, even in the cycle resp_ready=1. Acceptance occurs in the following IDLE cycle.
- Reset mid-operation: rst=0 in BUSY or RESP returns the FSM to IDLE with all outputs at reset values.
  - A store not yet committed (reset before the commit edge) is dropped.
  - A committed store remains in the array.
- Out-of-range check uses the full req_addr[31:2], not a truncated index, so address 32'h0000_0200 with DEPTH=128 sets err.

## Test plan
- Reset then load addr 0x0000_0010, LATENCY=2, resp_ready=1:
  - resp_valid rises exactly 3 cycles after acceptance.
  - resp_rdata=0x0000_0004, resp_err=0.
- Store addr 0x0000_0020, wdata 0xDEAD_BEEF, be=4'b0101, then load 0x0000_0020 → resp_rdata=0x00AD_00EF (original word 8 = 0x0000_0008 with lanes 0 and 2 replaced).
- Load 0x0000_0013 (misaligned) and 0x0000_0200 (out of range) → resp_err=1, resp_rdata=0, array unchanged (reload 0x0000_0010 still returns 4).
- Hold resp_ready=0 for 5 cycles with req_valid=1 → resp_valid/resp_rdata stable throughout and req_ready=0. After resp_ready pulses, next request is accepted one cycle later.
- Store 0x1234_5678 to 0x0000_0004 with rst driven low during the first BUSY cycle → FSM returns to IDLE, no response issued, later load of 0x0000_0004 returns 0x0000_0001.
- LATENCY=0 build: back-to-back loads of addresses 0, 4, 8 with resp_ready=1 → responses 0, 1, 2, each arriving one cycle after acceptance, one transaction every 2 cycles.
